mode_scheduler: RTL and testbench

//  Top-level mode controller for the MFC watch. Arbitrates the shared 5-button pad and the
//  4-digit display between time-set, alarm-set and stopwatch, drives the time counter run

---
 rtl/mode_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_mode_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mode_scheduler.sv
// -----------------------------------------------------------------------------
// mode_scheduler
//
// Top-level mode controller for the MFC watch. It arbitrates the shared
// 5-button pad and the 4-digit display between time-set, alarm-set and
// stopwatch. It drives the time counter run enable and sequences the
// alarm-ring state machine. Every output is registered.
//
// Parameters
//   RING_SECS   alarm ring duration in 1 s ticks before auto-stop (1..63)
//   SWITCH_GAP  dead cycles inserted on every mode change (1..15)
//
// Ports
//   MCLK          in   board clock, the only clock
//   RESET         in   synchronous, active-low reset
//   req_clk_set   in   request time-set mode (highest priority)
//   req_alm_set   in   request alarm-set mode
//   req_stopwatch in   request stopwatch mode (lowest priority)
//   alarm_on      in   alarm enable switch
//   alarm_match   in   1-cycle pulse: current time equals alarm time
//   tick_1s       in   1-cycle pulse once per second
//   btn_in[4:0]   in   filtered button pulses {center,right,left,dec,inc}
//   mode[1:0]     out  0 NORMAL, 1 CLK_SET, 2 ALM_SET, 3 STOPWATCH
//   switching     out  high during the mode-change dead window
//   time_run      out  time counter enable (low only while setting time)
//   clk_set_btn   out  {right,left,dec,inc} for time_set
//   alm_set_btn   out  {right,left,dec,inc} for alarm_set
//   sw_btn        out  all five buttons for the stopwatch
//   disp_sel[1:0] out  display source: 0 time, 1 time-set, 2 alarm, 3 stopwatch
//   ringing       out  alarm ring active
// -----------------------------------------------------------------------------
module mode_scheduler #(
    parameter int RING_SECS  = 30,
    parameter int SWITCH_GAP = 2
) (
    input  logic       MCLK,
    input  logic       RESET,
    input  logic       req_clk_set,
    input  logic       req_alm_set,
    input  logic       req_stopwatch,
    input  logic       alarm_on,
    input  logic       alarm_match,
    input  logic       tick_1s,
    input  logic [4:0] btn_in,
    output logic [1:0] mode,
    output logic       switching,
    output logic       time_run,
    output logic [3:0] clk_set_btn,
    output logic [3:0] alm_set_btn,
    output logic [4:0] sw_btn,
    output logic [1:0] disp_sel,
    output logic       ringing
);

    localparam logic [1:0] M_NORMAL    = 2'd0;
    localparam logic [1:0] M_CLK_SET   = 2'd1;
    localparam logic [1:0] M_ALM_SET   = 2'd2;
    localparam logic [1:0] M_STOPWATCH = 2'd3;

    localparam logic [0:0] ST_ACTIVE = 1'b0;
    localparam logic [0:0] ST_GAP    = 1'b1;

    localparam logic [0:0] AL_IDLE = 1'b0;
    localparam logic [0:0] AL_RING = 1'b1;

    localparam logic [5:0] RING_LOAD = 6'(RING_SECS);
    // The gap counter counts down to zero, so it is loaded with one less than
    // the number of dead cycles.
    localparam logic [3:0] GAP_LAST  = 4'(SWITCH_GAP - 1);

    logic [0:0] mode_state, mode_state_nx;
    logic [1:0] mode_nx;
    logic [1:0] target;
    logic [3:0] gap_cnt, gap_cnt_nx;

    logic [0:0] alm_state, alm_state_nx;
    logic [5:0] ring_cnt, ring_cnt_nx;

    logic       center_dismiss;
    logic [4:0] btn_eff;
    logic [3:0] clk_set_btn_nx;
    logic [3:0] alm_set_btn_nx;
    logic [4:0] sw_btn_nx;
    logic       time_run_nx;
    logic [1:0] disp_sel_nx;

    // Fixed-priority target mode selection.
    always_comb begin
        if (req_clk_set)        target = M_CLK_SET;
        else if (req_alm_set)   target = M_ALM_SET;
        else if (req_stopwatch) target = M_STOPWATCH;
        else                    target = M_NORMAL;
    end

    // Mode FSM. The gap always runs to completion once started; the target is
    // only sampled again on the last gap cycle, so a request that flips back
    // to the old mode simply re-enters it after the full gap.
    always_comb begin
        mode_state_nx = mode_state;
        mode_nx       = mode;
        gap_cnt_nx    = gap_cnt;
        case (mode_state)
            ST_ACTIVE: begin
                if (target != mode) begin
                    mode_state_nx = ST_GAP;
                    gap_cnt_nx    = GAP_LAST;
                end
            end
            default: begin
                if (gap_cnt == 4'd0) begin
                    mode_state_nx = ST_ACTIVE;
                    mode_nx       = target;
                end else begin
                    gap_cnt_nx = gap_cnt - 4'd1;
                end
            end
        endcase
    end

    // Alarm ring FSM. A dismiss (center press or alarm switch off) wins over
    // a tick in the same cycle; alarm_match is ignored while ringing.
    always_comb begin
        alm_state_nx = alm_state;
        ring_cnt_nx  = ring_cnt;
        case (alm_state)
            AL_IDLE: begin
                if (alarm_match && alarm_on && (mode != M_ALM_SET)) begin
                    alm_state_nx = AL_RING;
                    ring_cnt_nx  = RING_LOAD;
                end
            end
            default: begin
                if (!alarm_on || btn_in[4]) begin
                    alm_state_nx = AL_IDLE;
                    ring_cnt_nx  = 6'd0;
                end else if (tick_1s) begin
                    ring_cnt_nx = ring_cnt - 6'd1;
                    if (ring_cnt == 6'd1) alm_state_nx = AL_IDLE;
                end
            end
        endcase
    end

    // Button routing uses the state during the cycle the pulse arrives. A
    // center press that dismisses the ring is swallowed here.
    assign center_dismiss = (alm_state == AL_RING) && btn_in[4];
    assign btn_eff        = btn_in & ~{center_dismiss, 4'b0000};

    always_comb begin
        clk_set_btn_nx = 4'd0;
        alm_set_btn_nx = 4'd0;
        sw_btn_nx      = 5'd0;
        if (mode_state == ST_ACTIVE) begin
            case (mode)
                M_CLK_SET:   clk_set_btn_nx = btn_eff[3:0];
                M_ALM_SET:   alm_set_btn_nx = btn_eff[3:0];
                M_STOPWATCH: sw_btn_nx      = btn_eff;
                default:     ;
            endcase
        end
    end

    // mode keeps its old value through the gap, so mirroring mode also gives
    // the "hold during gap" behaviour for the display select.
    assign time_run_nx = !((mode_state_nx == ST_ACTIVE) && (mode_nx == M_CLK_SET));
    assign disp_sel_nx = ((alm_state_nx == AL_RING) && (mode_nx != M_STOPWATCH))
                         ? 2'd0 : mode_nx;

    always_ff @(posedge MCLK) begin
        if (!RESET) begin
            mode_state  <= ST_ACTIVE;
            mode        <= M_NORMAL;
            gap_cnt     <= 4'd0;
            alm_state   <= AL_IDLE;
            ring_cnt    <= 6'd0;
            switching   <= 1'b0;
            time_run    <= 1'b1;
            clk_set_btn <= 4'd0;
            alm_set_btn <= 4'd0;
            sw_btn      <= 5'd0;
            disp_sel    <= 2'd0;
            ringing     <= 1'b0;
        end else begin
            mode_state  <= mode_state_nx;
            mode        <= mode_nx;
            gap_cnt     <= gap_cnt_nx;
            alm_state   <= alm_state_nx;
            ring_cnt    <= ring_cnt_nx;
            switching   <= (mode_state_nx == ST_GAP);
            time_run    <= time_run_nx;
            clk_set_btn <= clk_set_btn_nx;
            alm_set_btn <= alm_set_btn_nx;
            sw_btn      <= sw_btn_nx;
            disp_sel    <= disp_sel_nx;
            ringing     <= (alm_state_nx == AL_RING);
        end
    end

endmodule

// File: tb/tb_mode_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mode_scheduler
//
// Self-checking bench for mode_scheduler with RING_SECS=3, SWITCH_GAP=2.
// A behavioural model tracks mode, remaining gap cycles and remaining ring
// seconds as plain integers; one compare process checks every output on
// every falling edge. Directed steps with literal expectations come first,
// then a randomized run.
// -----------------------------------------------------------------------------
module tb_mode_scheduler;

    localparam int RS = 3;
    localparam int SG = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_clk_set, req_alm_set, req_stopwatch;
    logic       alarm_on, alarm_match, tick_1s;
    logic [4:0] btn_in;
    logic [1:0] mode;
    logic       switching, time_run, ringing;
    logic [3:0] clk_set_btn, alm_set_btn;
    logic [4:0] sw_btn;
    logic [1:0] disp_sel;

    always #5 clk = ~clk;

    mode_scheduler #(.RING_SECS(RS), .SWITCH_GAP(SG)) dut (
        .MCLK(clk), .RESET(rst_n),
        .req_clk_set(req_clk_set), .req_alm_set(req_alm_set),
        .req_stopwatch(req_stopwatch), .alarm_on(alarm_on),
        .alarm_match(alarm_match), .tick_1s(tick_1s), .btn_in(btn_in),
        .mode(mode), .switching(switching), .time_run(time_run),
        .clk_set_btn(clk_set_btn), .alm_set_btn(alm_set_btn),
        .sw_btn(sw_btn), .disp_sel(disp_sel), .ringing(ringing)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: integers for mode, gap cycles left, ring seconds left.
    int         m_mode = 0;
    int         m_gap  = 0;
    int         m_ring = 0;
    int         tgt;
    logic [4:0] b;
    logic [3:0] e_clk_btn = '0, e_alm_btn = '0;
    logic [4:0] e_sw_btn = '0;
    logic       model_valid = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = 0; m_gap = 0; m_ring = 0;
            e_clk_btn = '0; e_alm_btn = '0; e_sw_btn = '0;
        end else begin
            tgt = req_clk_set ? 1 : req_alm_set ? 2 : req_stopwatch ? 3 : 0;
            b = btn_in;
            if (m_ring > 0) b[4] = 1'b0;
            e_clk_btn = (m_gap == 0 && m_mode == 1) ? b[3:0] : 4'd0;
            e_alm_btn = (m_gap == 0 && m_mode == 2) ? b[3:0] : 4'd0;
            e_sw_btn  = (m_gap == 0 && m_mode == 3) ? b : 5'd0;
            if (m_ring == 0) begin
                if (alarm_match && alarm_on && m_mode != 2) m_ring = RS;
            end else if (!alarm_on || btn_in[4]) begin
                m_ring = 0;
            end else if (tick_1s) begin
                m_ring = m_ring - 1;
            end
            if (m_gap == 0) begin
                if (tgt != m_mode) m_gap = SG;
            end else begin
                m_gap = m_gap - 1;
                if (m_gap == 0) m_mode = tgt;
            end
        end
        model_valid = 1'b1;
    end

    // Single compare process against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            chk("mode",        8'(mode),        8'(m_mode));
            chk("switching",   8'(switching),   8'(m_gap > 0));
            chk("time_run",    8'(time_run),    8'(!(m_gap == 0 && m_mode == 1)));
            chk("ringing",     8'(ringing),     8'(m_ring > 0));
            chk("disp_sel",    8'(disp_sel),    8'((m_ring > 0 && m_mode != 3) ? 0 : m_mode));
            chk("clk_set_btn", 8'(clk_set_btn), 8'(e_clk_btn));
            chk("alm_set_btn", 8'(alm_set_btn), 8'(e_alm_btn));
            chk("sw_btn",      8'(sw_btn),      8'(e_sw_btn));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req_clk_set = 0; req_alm_set = 0; req_stopwatch = 0;
        alarm_on = 0; alarm_match = 0; tick_1s = 0; btn_in = '0;
        step(); step();
        chk("rst_mode", 8'(mode), 8'd0);
        chk("rst_time_run", 8'(time_run), 8'd1);
        chk("rst_ringing", 8'(ringing), 8'd0);
        chk("rst_disp", 8'(disp_sel), 8'd0);
        chk("rst_switching", 8'(switching), 8'd0);
        rst_n = 1'b1;

        // NORMAL -> CLK_SET with a dropped inc during the gap.
        req_clk_set = 1; step();
        chk("gap1_switching", 8'(switching), 8'd1);
        chk("gap1_mode", 8'(mode), 8'd0);
        btn_in = 5'b00001; step(); btn_in = '0;
        chk("gap_inc_dropped", 8'(clk_set_btn), 8'd0);
        chk("gap2_switching", 8'(switching), 8'd1);
        step();
        chk("clkset_mode", 8'(mode), 8'd1);
        chk("clkset_switching", 8'(switching), 8'd0);
        chk("clkset_time_run", 8'(time_run), 8'd0);
        btn_in = 5'b00001; step(); btn_in = '0;
        chk("clkset_inc", 8'(clk_set_btn), 8'b0001);
        step();
        chk("clkset_inc_gone", 8'(clk_set_btn), 8'd0);

        // Priority, then drop clk_set -> STOPWATCH.
        req_stopwatch = 1; step();
        chk("prio_mode", 8'(mode), 8'd1);
        req_clk_set = 0; step();
        chk("to_sw_gap", 8'(switching), 8'd1);
        step(); step();
        chk("sw_mode", 8'(mode), 8'd3);
        chk("sw_time_run", 8'(time_run), 8'd1);
        btn_in = 5'b00100; step(); btn_in = '0;
        chk("sw_left", 8'(sw_btn), 8'b00100);
        chk("sw_clk_btn_zero", 8'(clk_set_btn), 8'd0);

        // Ring for three ticks.
        alarm_on = 1; alarm_match = 1; step(); alarm_match = 0;
        chk("ring_start", 8'(ringing), 8'd1);
        chk("ring_disp_sw", 8'(disp_sel), 8'd3);
        for (int i = 0; i < 3; i++) begin
            tick_1s = 1; step(); tick_1s = 0;
            chk("ring_tick", 8'(ringing), 8'((i < 2) ? 1 : 0));
        end

        // Center dismiss is swallowed.
        alarm_match = 1; step(); alarm_match = 0;
        chk("ring2_start", 8'(ringing), 8'd1);
        btn_in = 5'b10000; step(); btn_in = '0;
        chk("center_dismiss", 8'(ringing), 8'd0);
        chk("center_consumed", 8'(sw_btn), 8'd0);

        // Alarm switch off mid-ring.
        alarm_match = 1; step(); alarm_match = 0;
        chk("ring3_start", 8'(ringing), 8'd1);
        alarm_on = 0; step(); alarm_on = 1;
        chk("alarm_off_stop", 8'(ringing), 8'd0);

        // Reset mid-ring in STOPWATCH.
        alarm_match = 1; step(); alarm_match = 0;
        chk("ring4_start", 8'(ringing), 8'd1);
        rst_n = 0; step(); rst_n = 1;
        chk("rst2_mode", 8'(mode), 8'd0);
        chk("rst2_ringing", 8'(ringing), 8'd0);
        chk("rst2_time_run", 8'(time_run), 8'd1);
        chk("rst2_disp", 8'(disp_sel), 8'd0);

        // ALM_SET blocks new rings and receives buttons.
        req_alm_set = 1; step(); step(); step();
        chk("almset_mode", 8'(mode), 8'd2);
        alarm_match = 1; step(); alarm_match = 0;
        chk("almset_no_ring", 8'(ringing), 8'd0);
        btn_in = 5'b00010; step(); btn_in = '0;
        chk("almset_dec", 8'(alm_set_btn), 8'b0010);
        req_alm_set = 0; req_stopwatch = 0;

        // Randomized run.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(15) == 0) req_clk_set   = 1'($urandom_range(1));
            if ($urandom_range(11) == 0) req_alm_set   = 1'($urandom_range(1));
            if ($urandom_range(9)  == 0) req_stopwatch = 1'($urandom_range(1));
            alarm_on    = ($urandom_range(19) != 0);
            alarm_match = ($urandom_range(11) == 0);
            tick_1s     = ($urandom_range(2) == 0);
            btn_in      = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'd0;
            rst_n       = ($urandom_range(399) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
